lbc_async_rx_mc: RTL and testbench

- Receive side of a multi-channel toggle-handshake local-bus crossing. Generalises the single-channel valid/ack toggle synchroniser.
- Features added here:
  - CHANNELS independent request channels, each carrying a WIDTH-bit bundled payload.
  - Configurable synchroniser depth.
  - Per-channel payload capture.
  - Round-robin merge of all channels onto one valid/ready output port.
- Sits entirely in the receiving clock domain. Request toggles arrive from the sender domain; ack toggles are returned to the sender.

---
 rtl/lbc_async_rx_mc.sv | 145 ++++++++++++++
 tb/tb_lbc_async_rx_mc.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/lbc_async_rx_mc.sv
// rtl/lbc_async_rx_mc.sv - multi-channel toggle-handshake receiver with round-robin merge; LBC_RX_ERR_CHECK_EN adds sticky ERRO
module lbc_async_rx_mc #(
    parameter int  CHANNELS    = 4,
    parameter int  WIDTH       = 32,
    parameter int  SYNC_STAGES = 2,
    localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      CLOCKOI,
    input  logic                      RESET_D1_OR,
    input  logic                      LBC_SYNC_MODE,
    input  logic [CHANNELS-1:0]       REQ_TOGGLEI,
    input  logic [CHANNELS*WIDTH-1:0] DATAI,
    output logic [CHANNELS-1:0]       ACK_TOGGLEO,
    output logic                      VALIDO,
    output logic [WIDTH-1:0]          DATAO,
    output logic [CW-1:0]             CHANO,
    input  logic                      READYI,
    output logic                      ERRO
);

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] sync_out;
    logic [CHANNELS-1:0] seen_q;
    logic [CHANNELS-1:0] pending_q;
    logic [CHANNELS-1:0] ack_q;
    logic [WIDTH-1:0]    hold_q [CHANNELS];
    logic [CW-1:0]       ptr_q;
    logic                valid_q;
    logic [WIDTH-1:0]    data_q;
    logic [CW-1:0]       chan_q;

    logic [CHANNELS-1:0] req_evt;
    logic [CHANNELS-1:0] in_out;
    logic [CHANNELS-1:0] elig;
    logic [CHANNELS-1:0] grant;
    logic [CHANNELS-1:0] xfer_vec;
    logic [CW-1:0]       win;
    logic [WIDTH-1:0]    win_data;
    logic                found;
    logic                xfer;
    logic                load_en;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign req_evt  = LBC_SYNC_MODE ? '0 : (sync_out ^ seen_q);
    assign xfer     = valid_q && READYI;

    // The word sitting in the output register is never re-offered until it leaves
    always_comb begin
        in_out   = '0;
        xfer_vec = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            in_out[c]   = valid_q && (chan_q == CW'(c));
            xfer_vec[c] = xfer && (chan_q == CW'(c));
        end
        elig = (LBC_SYNC_MODE ? REQ_TOGGLEI : pending_q) & ~in_out;
    end

    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        for (int i = 1; i <= CHANNELS; i++) begin
            int idx;
            idx = (int'(ptr_q) + i) % CHANNELS;
            if (!found && elig[idx]) begin
                found      = 1'b1;
                win        = CW'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (win == CW'(c)) begin
                win_data = LBC_SYNC_MODE ? DATAI[c*WIDTH +: WIDTH] : hold_q[c];
            end
        end
    end

    assign load_en     = (!valid_q || READYI) && found;
    assign ACK_TOGGLEO = LBC_SYNC_MODE ? (grant & {CHANNELS{load_en}}) : ack_q;

    always_ff @(posedge CLOCKOI) begin
        if (RESET_D1_OR) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            for (int c = 0; c < CHANNELS; c++) hold_q[c] <= '0;
            seen_q    <= '0;
            pending_q <= '0;
            ack_q     <= '0;
            ptr_q     <= CW'(CHANNELS - 1);
            valid_q   <= 1'b0;
            data_q    <= '0;
            chan_q    <= '0;
        end else begin
            sync_q[0] <= REQ_TOGGLEI;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];

            // A transfer wins over a same-cycle event; an event on a busy channel is dropped
            if (!LBC_SYNC_MODE) begin
                seen_q <= sync_out;
                for (int c = 0; c < CHANNELS; c++) begin
                    if (xfer_vec[c]) begin
                        pending_q[c] <= 1'b0;
                        ack_q[c]     <= ~ack_q[c];
                    end else if (req_evt[c] && !pending_q[c]) begin
                        pending_q[c] <= 1'b1;
                        hold_q[c]    <= DATAI[c*WIDTH +: WIDTH];
                    end
                end
            end

            if (load_en) begin
                valid_q <= 1'b1;
                data_q  <= win_data;
                chan_q  <= win;
                ptr_q   <= win;
            end else if (xfer) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign VALIDO = valid_q;
    assign DATAO  = data_q;
    assign CHANO  = chan_q;

`ifdef LBC_RX_ERR_CHECK_EN
    logic err_q;

    always_ff @(posedge CLOCKOI) begin
        if (RESET_D1_OR) begin
            err_q <= 1'b0;
        end else if (!LBC_SYNC_MODE && |(req_evt & pending_q)) begin
            err_q <= 1'b1;
        end
    end

    assign ERRO = err_q;
`else
    assign ERRO = 1'b0;
`endif

endmodule

// File: tb/tb_lbc_async_rx_mc.sv
// tb/tb_lbc_async_rx_mc.sv - directed self-checking bench for lbc_async_rx_mc
module tb_lbc_async_rx_mc;

    localparam int CH = 4;
    localparam int W  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            sync_mode;
    logic [CH-1:0]   req;
    logic [CH*W-1:0] datai;
    logic [CH-1:0]   ack;
    logic            valid;
    logic [W-1:0]    datao;
    logic [1:0]      chan;
    logic            ready;
    logic            err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lbc_async_rx_mc #(.CHANNELS(CH), .WIDTH(W), .SYNC_STAGES(2)) dut (
        .CLOCKOI       (clk),
        .RESET_D1_OR   (rst),
        .LBC_SYNC_MODE (sync_mode),
        .REQ_TOGGLEI   (req),
        .DATAI         (datai),
        .ACK_TOGGLEO   (ack),
        .VALIDO        (valid),
        .DATAO         (datao),
        .CHANO         (chan),
        .READYI        (ready),
        .ERRO          (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic mode);
        rst       = 1'b1;
        sync_mode = mode;
        req       = '0;
        datai     = '0;
        ready     = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    logic [W-1:0] cur_data [2];
    logic [1:0]   last_ack;
    int           seqn [2];
    int           k;
    logic         exp_err;

    initial begin
`ifdef LBC_RX_ERR_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        // reset state
        do_reset(1'b0);
        check("rst_valid", valid, 0);
        check("rst_ack",   ack,   0);
        check("rst_err",   err,   0);
        check("rst_chan",  chan,  0);
        check("rst_data",  datao, 0);

        // single word on ch0, latency S+2
        ready = 1'b1;
        datai[0*W +: W] = 32'hA5A5_0001;
        req[0] = 1'b1;
        tick(3);
        check("t1_valid_e3", valid, 0);
        tick(1);
        check("t1_valid_e4", valid, 1);
        check("t1_data",     datao, 32'hA5A5_0001);
        check("t1_chan",     chan,  0);
        check("t1_ack_pre",  ack,   4'b0000);
        tick(1);
        check("t1_ack_post", ack,   4'b0001);
        check("t1_valid_end", valid, 0);

        // all four channels at once
        do_reset(1'b0);
        ready = 1'b1;
        for (int c = 0; c < CH; c++) datai[c*W +: W] = 32'h10 + c;
        req = 4'hF;
        tick(4);
        for (int c = 0; c < CH; c++) begin
            check($sformatf("t2_chan%0d", c), chan, c);
            check($sformatf("t2_data%0d", c), datao, 32'h10 + c);
            check($sformatf("t2_ack%0d", c), ack, (4'b0001 << c) - 4'b0001);
            tick(1);
        end
        check("t2_ack_final", ack, 4'hF);
        check("t2_valid_end", valid, 0);

        // back-pressure with ch2 loaded and ch3 pending
        do_reset(1'b0);
        datai[2*W +: W] = 32'h2222_0002;
        datai[3*W +: W] = 32'h3333_0003;
        req = 4'b1100;
        tick(4);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_chan", chan,  2);
            check("t3_hold_data", datao, 32'h2222_0002);
            check("t3_hold_ack",  ack,   4'b0000);
            tick(1);
        end
        ready = 1'b1;
        tick(1);
        check("t3_ch3_chan", chan,  3);
        check("t3_ch3_data", datao, 32'h3333_0003);
        check("t3_ack_ch2",  ack,   4'b0100);
        tick(1);
        check("t3_ack_ch3",  ack,   4'b1100);
        check("t3_valid_end", valid, 0);

        // round-robin fairness between two greedy channels
        do_reset(1'b0);
        ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            seqn[c] = 0;
            cur_data[c] = 32'hC000_0000 | (c << 8);
            datai[c*W +: W] = cur_data[c];
        end
        last_ack = 2'b00;
        k = 0;
        req = 4'b0011;
        for (int cyc = 0; cyc < 400 && k < 20; cyc++) begin
            tick(1);
            if (valid) begin
                check($sformatf("t4_chan_%0d", k), chan, k % 2);
                check($sformatf("t4_data_%0d", k), datao, cur_data[k % 2]);
                k++;
            end
            for (int c = 0; c < 2; c++) begin
                if (ack[c] != last_ack[c]) begin
                    last_ack[c] = ack[c];
                    seqn[c]++;
                    cur_data[c] = 32'hC000_0000 | (c << 8) | seqn[c];
                    datai[c*W +: W] = cur_data[c];
                    req[c] = ~req[c];
                end
            end
        end
        check("t4_transfers", k, 20);

        // sync mode: level valid, combinational ack
        do_reset(1'b1);
        ready = 1'b1;
        datai[1*W +: W] = 32'h5151_0001;
        datai[2*W +: W] = 32'h5252_0002;
        req = 4'b0110;
        #1;
        check("t5_ack_ch1",  ack, 4'b0010);
        tick(1);
        check("t5_valid",    valid, 1);
        check("t5_chan1",    chan,  1);
        check("t5_data1",    datao, 32'h5151_0001);
        check("t5_ack_ch2",  ack,   4'b0100);
        tick(1);
        check("t5_chan2",    chan,  2);
        check("t5_data2",    datao, 32'h5252_0002);

        // double toggle on ch1 before its ack
        do_reset(1'b0);
        datai[1*W +: W] = 32'hDEAD_0001;
        req[1] = 1'b1;
        tick(4);
        check("t6_chan",   chan,  1);
        datai[1*W +: W] = 32'hBEEF_0002;
        req[1] = 1'b0;
        tick(5);
        check("t6_err",    err,   exp_err);
        check("t6_data",   datao, 32'hDEAD_0001);
        ready = 1'b1;
        tick(1);
        check("t6_ack",    ack,   4'b0010);
        tick(3);
        check("t6_no_extra", valid, 0);
        check("t6_err_sticky", err, exp_err);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
